// File: rtl/experiment_host_framer.sv
// Host byte-stream framer: assembles 8-byte command/data frames, pulses commit,
// samples data_out after RESP_DELAY cycles and returns it as 4 bytes on a valid/ready TX stream.
module experiment_host_framer #(
    parameter int RESP_DELAY     = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] command,
    output logic [31:0] data_in,
    output logic        commit,
    input  logic [31:0] data_out,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_overrun,
    input  logic        err_clear
);

    localparam logic [1:0] ST_RX     = 2'd0;
    localparam logic [1:0] ST_COMMIT = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_TX     = 2'd3;

    localparam int              IDLE_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      DLY_MAX  = 8'(RESP_DELAY);

    logic [1:0]        state;
    logic [2:0]        byte_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [55:0]       asm_reg;
    logic [7:0]        dly_cnt;
    logic [31:0]       resp;
    logic [1:0]        tx_idx;

    logic timeout_hit;
    logic overrun_hit;

    // Only the first 7 bytes need storing; byte 7 goes straight into data_in.
    assign timeout_hit = (state == ST_RX) && (byte_cnt != 3'd0) && !rx_valid
                         && (idle_cnt == IDLE_MAX);
    assign overrun_hit = rx_valid && busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RX;
            byte_cnt <= 3'd0;
            idle_cnt <= '0;
            asm_reg  <= '0;
            dly_cnt  <= 8'd0;
            resp     <= 32'd0;
            tx_idx   <= 2'd0;
            command  <= 32'd0;
            data_in  <= 32'd0;
            commit   <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'd0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_RX: begin
                    if (rx_valid) begin
                        asm_reg  <= {asm_reg[47:0], rx_data};
                        byte_cnt <= byte_cnt + 3'd1;
                        idle_cnt <= '0;
                        if (byte_cnt == 3'd7) begin
                            command <= asm_reg[55:24];
                            data_in <= {asm_reg[23:0], rx_data};
                            commit  <= 1'b1;
                            busy    <= 1'b1;
                            state   <= ST_COMMIT;
                        end
                    end else if (byte_cnt == 3'd0) begin
                        idle_cnt <= '0;
                    end else if (timeout_hit) begin
                        byte_cnt <= 3'd0;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    commit  <= 1'b0;
                    dly_cnt <= 8'd1;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // dly_cnt equals k during cycle C+k, so this samples at the end of C+RESP_DELAY.
                    if (dly_cnt == DLY_MAX) begin
                        resp     <= data_out;
                        tx_data  <= data_out[31:24];
                        tx_valid <= 1'b1;
                        tx_idx   <= 2'd0;
                        state    <= ST_TX;
                    end else begin
                        dly_cnt <= dly_cnt + 8'd1;
                    end
                end
                ST_TX: begin
                    if (tx_valid && tx_ready) begin
                        if (tx_idx == 2'd3) begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            byte_cnt <= 3'd0;
                            state    <= ST_RX;
                        end else begin
                            resp    <= {resp[23:0], 8'd0};
                            tx_data <= resp[23:16];
                            tx_idx  <= tx_idx + 2'd1;
                        end
                    end
                end
                default: state <= ST_RX;
            endcase
        end
    end

    // A set event in the same cycle as err_clear keeps the flag high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (timeout_hit)    err_timeout <= 1'b1;
            else if (err_clear) err_timeout <= 1'b0;
            if (overrun_hit)    err_overrun <= 1'b1;
            else if (err_clear) err_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_experiment_host_framer.sv
// Directed bench for experiment_host_framer; wrapper modelled as data_out = command ^ data_in.
module tb_experiment_host_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] command;
    logic [31:0] data_in;
    logic        commit;
    logic [31:0] data_out;
    logic        busy;
    logic        err_timeout;
    logic        err_overrun;
    logic        err_clear;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign data_out = command ^ data_in;

    experiment_host_framer #(
        .RESP_DELAY    (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .command    (command),
        .data_in    (data_in),
        .commit     (commit),
        .data_out   (data_out),
        .busy       (busy),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun),
        .err_clear  (err_clear)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Observation of the output side, taken on the falling edge.
    int         cyc = 0;
    int         commit_cnt = 0;
    int         commit_cyc = 0;
    int         txv_cyc = 0;
    int         stab_err = 0;
    logic [7:0] got[$];
    logic       prev_txv = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_txd = 8'd0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            prev_txv   = 1'b0;
        end else begin
            if (commit) begin
                commit_cnt++;
                commit_cyc = cyc;
            end
            if (tx_valid && !prev_txv) txv_cyc = cyc;
            if (prev_stall && (!tx_valid || tx_data !== prev_txd)) stab_err++;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_txd   = tx_data;
            prev_txv   = tx_valid;
        end
    end

    // tx_ready pattern: always ready, or 1 cycle on / 2 cycles off.
    logic ready_mode = 1'b0;
    int   phase = 0;
    always @(posedge clk) begin
        #1;
        if (ready_mode) begin
            tx_ready = (phase == 0);
            phase    = (phase + 1) % 3;
        end else begin
            tx_ready = 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] cmd, input logic [31:0] din, input int gap);
        logic [63:0] f;
        f = {cmd, din};
        for (int i = 0; i < 8; i++) begin
            if (i > 0) idle(gap);
            send_byte(f[63-8*i -: 8]);
        end
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int k;
        k = 0;
        while (got.size() < n && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq({tag, "_arrived"}, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic check_resp(input string tag, input logic [31:0] exp);
        check_eq({tag, "_nbytes"}, 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[31-8*i -: 8]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        rx_data   = 8'd0;
        rx_valid  = 1'b0;
        tx_ready  = 1'b1;
        err_clear = 1'b0;
        idle(3);
        check_eq("rst_command", command, 32'd0);
        check_eq("rst_data_in", data_in, 32'd0);
        check_eq("rst_outs", 32'({commit, tx_valid, busy, err_timeout, err_overrun}), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic frame, tx always ready.
        got.delete();
        commit_cnt = 0;
        send_frame(32'h12345678, 32'hAABBCCDD, 0);
        check_eq("t1_commit", 32'(commit), 32'd1);
        check_eq("t1_command", command, 32'h12345678);
        check_eq("t1_data_in", data_in, 32'hAABBCCDD);
        check_eq("t1_busy", 32'(busy), 32'd1);
        wait_bytes("t1", 4);
        check_eq("t1_busy_done", 32'(busy), 32'd0);
        check_eq("t1_txv_done", 32'(tx_valid), 32'd0);
        idle(3);
        check_resp("t1", 32'hB88F9AA5);
        check_eq("t1_latency", 32'(txv_cyc - commit_cyc), 32'd3);
        check_eq("t1_commits", 32'(commit_cnt), 32'd1);

        // Same frame with a stalling consumer.
        got.delete();
        commit_cnt = 0;
        stab_err   = 0;
        ready_mode = 1'b1;
        send_frame(32'h12345678, 32'hAABBCCDD, 0);
        wait_bytes("t2", 4);
        idle(6);
        ready_mode = 1'b0;
        idle(1);
        check_resp("t2", 32'hB88F9AA5);
        check_eq("t2_stable", 32'(stab_err), 32'd0);
        check_eq("t2_commits", 32'(commit_cnt), 32'd1);

        // Partial frame times out after 16 idle cycles, not 15.
        got.delete();
        commit_cnt = 0;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        idle(15);
        check_eq("t3_no_timeout_yet", 32'(err_timeout), 32'd0);
        idle(1);
        check_eq("t3_timeout", 32'(err_timeout), 32'd1);
        check_eq("t3_no_commit", 32'(commit_cnt), 32'd0);
        send_frame(32'h00000001, 32'h00000002, 0);
        check_eq("t3_command", command, 32'h00000001);
        wait_bytes("t3", 4);
        idle(2);
        check_resp("t3", 32'h00000003);
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
        check_eq("t3_cleared", 32'(err_timeout), 32'd0);

        // Overrun during WAIT, then clear, then clear racing a new overrun.
        got.delete();
        commit_cnt = 0;
        send_frame(32'h01020304, 32'h10203040, 0);
        idle(1);
        send_byte(8'h55);
        check_eq("t4_overrun", 32'(err_overrun), 32'd1);
        wait_bytes("t4", 4);
        idle(2);
        check_resp("t4", 32'h11223344);
        check_eq("t4_commits", 32'(commit_cnt), 32'd1);
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
        check_eq("t4_clear_ovr", 32'(err_overrun), 32'd0);
        check_eq("t4_clear_to", 32'(err_timeout), 32'd0);
        got.delete();
        send_frame(32'hCAFEF00D, 32'h00000000, 0);
        idle(1);
        err_clear = 1'b1;
        send_byte(8'h55);
        err_clear = 1'b0;
        check_eq("t4_set_wins", 32'(err_overrun), 32'd1);
        wait_bytes("t4b", 4);
        idle(2);
        check_resp("t4b", 32'hCAFEF00D);

        // Reset in the middle of the response.
        got.delete();
        send_frame(32'h55555555, 32'h0000FFFF, 0);
        wait_bytes("t5_pre", 2);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_outs", 32'({commit, tx_valid, busy, err_timeout, err_overrun}), 32'd0);
        check_eq("t5_rst_cmd", command, 32'd0);
        check_eq("t5_rst_txd", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        got.delete();
        idle(8);
        check_eq("t5_no_emit", 32'(got.size()), 32'd0);
        send_frame(32'hA0B0C0D0, 32'h0F0E0D0C, 0);
        check_eq("t5_data_in", data_in, 32'h0F0E0D0C);
        wait_bytes("t5", 4);
        idle(2);
        check_resp("t5", 32'hAFBECDDC);

        // 15 idle cycles between bytes never times out.
        got.delete();
        commit_cnt = 0;
        send_frame(32'h00FF00FF, 32'h0F0F0F0F, 15);
        check_eq("t6_commit", 32'(commit), 32'd1);
        wait_bytes("t6", 4);
        idle(2);
        check_resp("t6", 32'h0FF00FF0);
        check_eq("t6_no_timeout", 32'(err_timeout), 32'd0);
        check_eq("t6_commits", 32'(commit_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
